adder_accumulator: RTL and testbench

Sequential accumulation stage that sits directly downstream of the `Adder` datapath. It consumes the adder's `{carry_out, sum}` result as a (WIDTH+1)-bit unsigned value through a valid/ready handshake. It sums a fixed-length frame of LEN results into a saturating ACC_WIDTH-bit accumulator. It then presents the frame total to the next stage, holding it until that stage accepts it.

---
 rtl/adder_accumulator_if.sv | 23 ++
 rtl/adder_accumulator.sv | 62 ++++++
 tb/tb_adder_accumulator.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/adder_accumulator_if.sv
// adder_accumulator_if: valid/ready beat input and frame-result output bundle
interface adder_accumulator_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH:0]       in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_data;
    logic                 out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/adder_accumulator.sv
// adder_accumulator: saturating sum of LEN adder results per frame, held until accepted
module adder_accumulator #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int LEN       = 4
) (
    input  logic                clk,
    input  logic                reset,
    adder_accumulator_if.slave  bus
);
    localparam int EXT_W = ACC_WIDTH + 1;
    localparam int CW    = $clog2(LEN + 1);

    typedef enum logic {ACCUM, DONE} state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d, out_data_q, out_data_d, acc_sum;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 ovf_q, ovf_d, out_ovf_q, out_ovf_d, ovf_sum;
    logic [EXT_W-1:0]     ext;
    logic                 accept, last, handoff;

    assign bus.in_ready  = (state_q == ACCUM) && !reset;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;

    // next state: accumulate with clamp on accepted beats, clear everything on handoff
    always_comb begin
        ext      = {1'b0, acc_q} + EXT_W'(bus.in_data[WIDTH:0]);
        acc_sum  = ext[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : ext[ACC_WIDTH-1:0];
        ovf_sum  = ovf_q | ext[ACC_WIDTH];
        accept   = bus.in_valid && bus.in_ready;
        last     = cnt_q == CW'(LEN - 1);
        handoff  = (state_q == DONE) && bus.out_ready;
        state_d    = handoff ? ACCUM : (accept && last) ? DONE : state_q;
        acc_d      = handoff ? '0 : accept ? acc_sum : acc_q;
        ovf_d      = handoff ? 1'b0 : accept ? ovf_sum : ovf_q;
        cnt_d      = handoff ? '0 : accept ? cnt_q + CW'(1) : cnt_q;
        out_data_d = handoff ? '0 : (accept && last) ? acc_sum : out_data_q;
        out_ovf_d  = handoff ? 1'b0 : (accept && last) ? ovf_sum : out_ovf_q;
    end

    // state registers with synchronous reset discarding any partial or pending frame
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end
endmodule

// File: tb/tb_adder_accumulator.sv
// tb_adder_accumulator: directed vector bench for LEN=4 and LEN=1 accumulators
module tb_adder_accumulator;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    adder_accumulator_if #(.WIDTH(8), .ACC_WIDTH(10)) b4 ();
    adder_accumulator_if #(.WIDTH(8), .ACC_WIDTH(10)) b1 ();

    adder_accumulator #(.WIDTH(8), .ACC_WIDTH(10), .LEN(4)) dut4 (
        .clk(clk), .reset(reset), .bus(b4.slave)
    );
    adder_accumulator #(.WIDTH(8), .ACC_WIDTH(10), .LEN(1)) dut1 (
        .clk(clk), .reset(reset), .bus(b1.slave)
    );

    typedef struct packed {
        logic [3:0][8:0] b;
        logic            gap;
        logic [9:0]      exp_data;
        logic            exp_ovf;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(int a0, int a1, int a2, int a3, bit g, int d, bit o);
        vec_t v;
        v.b[0] = 9'(a0);
        v.b[1] = 9'(a1);
        v.b[2] = 9'(a2);
        v.b[3] = 9'(a3);
        v.gap = g;
        v.exp_data = 10'(d);
        v.exp_ovf = o;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [3:0][8:0] b, input bit gap);
        for (int i = 0; i < 4; i++) begin
            b4.in_valid = 1'b1;
            b4.in_data  = b[i];
            chk("beat_in_ready", int'(b4.in_ready), 1);
            chk("beat_out_valid", int'(b4.out_valid), 0);
            step();
            if (gap && i < 3) begin
                b4.in_valid = 1'b0;
                b4.in_data  = 9'h1ff;
                step();
            end
        end
        b4.in_valid = 1'b0;
    endtask

    task automatic expect_result(input string name, input int d, input int o);
        chk({name, "_valid"}, int'(b4.out_valid), 1);
        chk({name, "_data"}, int'(b4.out_data), d);
        chk({name, "_ovf"}, int'(b4.out_ovf), o);
    endtask

    task automatic expect_cleared(input string name);
        chk({name, "_valid"}, int'(b4.out_valid), 0);
        chk({name, "_data"}, int'(b4.out_data), 0);
        chk({name, "_ovf"}, int'(b4.out_ovf), 0);
        chk({name, "_in_ready"}, int'(b4.in_ready), 1);
    endtask

    initial begin
        vecs[0] = mk(127, 300, 5, 10, 0, 442, 0);
        vecs[1] = mk(511, 511, 511, 511, 0, 1023, 1);
        vecs[2] = mk(1, 1, 1, 1, 0, 4, 0);
        vecs[3] = mk(127, 300, 5, 10, 1, 442, 0);
        vecs[4] = mk(0, 0, 0, 0, 0, 0, 0);
        vecs[5] = mk(511, 511, 1, 0, 0, 1023, 0);
        vecs[6] = mk(511, 511, 2, 0, 1, 1023, 1);

        reset = 1'b1;
        b4.in_valid = 1'b0; b4.in_data = '0; b4.out_ready = 1'b1;
        b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready_forced", int'(b4.in_ready), 0);
        chk("rst_out_valid", int'(b4.out_valid), 0);
        chk("rst_out_data", int'(b4.out_data), 0);
        chk("rst_out_ovf", int'(b4.out_ovf), 0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(b4.in_ready), 1);

        for (int k = 0; k < 7; k++) begin
            send(vecs[k].b, vecs[k].gap);
            expect_result($sformatf("vec%0d", k), int'(vecs[k].exp_data), int'(vecs[k].exp_ovf));
            step();
            expect_cleared($sformatf("vec%0d_handoff", k));
        end

        b4.out_ready = 1'b0;
        send(vecs[0].b, 1'b0);
        b4.in_valid = 1'b1;
        b4.in_data  = 9'd7;
        for (int c = 0; c < 5; c++) begin
            expect_result("bp_hold", 442, 0);
            chk("bp_in_ready", int'(b4.in_ready), 0);
            step();
        end
        b4.in_valid = 1'b0;
        b4.out_ready = 1'b1;
        expect_result("bp_xfer", 442, 0);
        step();
        expect_cleared("bp_after");
        step();
        chk("bp_single_xfer", int'(b4.out_valid), 0);
        send(vecs[2].b, 1'b0);
        expect_result("bp_no_stray_beat", 4, 0);
        step();

        for (int i = 0; i < 2; i++) begin
            b4.in_valid = 1'b1;
            b4.in_data  = 9'd50;
            step();
        end
        b4.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_in_ready", int'(b4.in_ready), 0);
        step();
        reset = 1'b0;
        #1;
        expect_cleared("mid_rst");
        send(mk(3, 3, 3, 3, 0, 12, 0).b, 1'b0);
        expect_result("mid_rst_frame", 12, 0);
        step();

        b4.out_ready = 1'b0;
        send(mk(3, 3, 3, 3, 0, 12, 0).b, 1'b0);
        expect_result("done_pre_rst", 12, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        expect_cleared("done_rst");
        b4.out_ready = 1'b1;
        step();
        chk("done_rst_no_valid", int'(b4.out_valid), 0);
        send(vecs[2].b, 1'b0);
        expect_result("done_rst_frame", 4, 0);
        step();

        chk("len1_idle_ready", int'(b1.in_ready), 1);
        b1.in_valid = 1'b1;
        b1.in_data  = 9'd9;
        step();
        b1.in_valid = 1'b0;
        chk("len1_valid", int'(b1.out_valid), 1);
        chk("len1_data", int'(b1.out_data), 9);
        chk("len1_ovf", int'(b1.out_ovf), 0);
        for (int c = 0; c < 2; c++) begin
            chk("len1_stall_ready", int'(b1.in_ready), 0);
            step();
        end
        b1.out_ready = 1'b1;
        chk("len1_hold_data", int'(b1.out_data), 9);
        step();
        chk("len1_after_valid", int'(b1.out_valid), 0);
        chk("len1_after_ready", int'(b1.in_ready), 1);
        chk("len1_after_data", int'(b1.out_data), 0);
        b1.in_valid = 1'b1;
        b1.in_data  = 9'd511;
        step();
        b1.in_valid = 1'b0;
        chk("len1_max_valid", int'(b1.out_valid), 1);
        chk("len1_max_data", int'(b1.out_data), 511);
        step();
        chk("len1_max_done", int'(b1.out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
